// File: rtl/cdec8_mem_responder.sv
// cdec8_mem_responder: CDEC8 bus RAM/IO responder with debug port and four-phase loader
module cdec8_mem_responder #(
  parameter int          ADDR_W  = 8,
  parameter logic [7:0]  IO_ADRS = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] adrs,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  input  logic       mmrd_N,
  input  logic       mmwr_N,
  output logic       cpu_hold,
  input  logic       ld_req,
  input  logic [7:0] ld_adrs,
  input  logic [7:0] ld_data,
  output logic       ld_ack,
  input  logic [7:0] in_port,
  output logic [7:0] out_port,
  input  logic [7:0] resad,
  output logic [7:0] resdt,
  output logic       bus_err
);
  typedef enum logic [1:0] {IDLE, HOLD, WRITE, ACK} state_t;
  state_t            state_q;
  logic              wr_prev_q;
  logic [7:0]        mem [2**ADDR_W];
  logic              rd, wr, cpu_en, cpu_we, we;
  logic [ADDR_W-1:0] wa;
  logic [7:0]        wd;
  always_comb begin
    rd     = !mmrd_N;
    wr     = !mmwr_N;
    cpu_en = state_q == IDLE || state_q == HOLD;
    cpu_we = cpu_en && wr && wr_prev_q && !rd;
    we     = !reset && (state_q == WRITE || (cpu_we && adrs != IO_ADRS));
    wa     = state_q == WRITE ? ld_adrs[ADDR_W-1:0] : adrs[ADDR_W-1:0];
    wd     = state_q == WRITE ? ld_data : cpu_wdata;
  end
  // RAM has no reset; contents survive reset by design
  always_ff @(posedge clock)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_prev_q <= 1'b1;
      cpu_rdata <= '0;
      resdt     <= '0;
      out_port  <= '0;
      cpu_hold  <= 1'b0;
      ld_ack    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      wr_prev_q <= mmwr_N;
      resdt     <= resad == IO_ADRS ? out_port : mem[resad[ADDR_W-1:0]];
      if (cpu_en && rd) cpu_rdata <= adrs == IO_ADRS ? in_port : mem[adrs[ADDR_W-1:0]];
      if (cpu_we && adrs == IO_ADRS) out_port <= cpu_wdata;
      if ((rd && wr) || (!cpu_en && (rd || wr))) bus_err <= 1'b1;
      case (state_q)
        IDLE: if (ld_req) begin
          state_q  <= HOLD;
          cpu_hold <= 1'b1;
        end
        HOLD: if (!ld_req) begin
          state_q  <= IDLE;
          cpu_hold <= 1'b0;
        end else if (!rd && !wr) state_q <= WRITE;
        WRITE: begin
          state_q <= ACK;
          ld_ack  <= 1'b1;
        end
        ACK: if (!ld_req) begin
          state_q  <= IDLE;
          ld_ack   <= 1'b0;
          cpu_hold <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cdec8_mem_responder.sv
// tb_cdec8_mem_responder: directed stimulus against a behavioural bus model plus literal checks
module tb_cdec8_mem_responder;
  logic       clock = 1'b0, reset;
  logic [7:0] adrs, cpu_wdata, cpu_rdata, ld_adrs, ld_data, in_port, out_port, resad, resdt;
  logic       mmrd_N, mmwr_N, cpu_hold, ld_req, ld_ack, bus_err;
  int         n_pass = 0, n_total = 0;

  cdec8_mem_responder dut (
    .clock(clock), .reset(reset), .adrs(adrs), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .mmrd_N(mmrd_N), .mmwr_N(mmwr_N), .cpu_hold(cpu_hold), .ld_req(ld_req), .ld_adrs(ld_adrs),
    .ld_data(ld_data), .ld_ack(ld_ack), .in_port(in_port), .out_port(out_port),
    .resad(resad), .resdt(resdt), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // behavioural model: bytes written, which bytes are known, loader phase 0..3
  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_rdata, m_resdt, m_out;
  bit         m_hold, m_ack, m_err, m_prev, m_rk, m_dk, started;
  int         m_ph, m_writes;

  always @(posedge clock) begin
    bit busy, rd, wr;
    if (reset) begin
      m_rdata = 0; m_resdt = 0; m_out = 0; m_hold = 0; m_ack = 0; m_err = 0;
      m_ph = 0; m_prev = 1; m_rk = 1; m_dk = 1;
    end else begin
      busy = m_ph >= 2;
      rd = !mmrd_N;
      wr = !mmwr_N;
      m_dk = resad == 8'hFF || m_known[resad];
      m_resdt = resad == 8'hFF ? m_out : m_mem[resad];
      if (rd && !busy) begin
        m_rk = adrs == 8'hFF || m_known[adrs];
        m_rdata = adrs == 8'hFF ? in_port : m_mem[adrs];
      end
      if ((rd && wr) || (busy && (rd || wr))) m_err = 1;
      if (wr && m_prev && !rd && !busy) begin
        m_writes++;
        if (adrs == 8'hFF) m_out = cpu_wdata;
        else begin m_mem[adrs] = cpu_wdata; m_known[adrs] = 1; end
      end
      if (m_ph == 0 && ld_req) begin m_ph = 1; m_hold = 1; end
      else if (m_ph == 1 && !ld_req) begin m_ph = 0; m_hold = 0; end
      else if (m_ph == 1 && !rd && !wr) m_ph = 2;
      else if (m_ph == 2) begin
        m_mem[ld_adrs] = ld_data; m_known[ld_adrs] = 1; m_ph = 3; m_ack = 1;
      end else if (m_ph == 3 && !ld_req) begin m_ph = 0; m_ack = 0; m_hold = 0; end
      m_prev = mmwr_N;
    end
    started = 1;
  end

  always @(negedge clock) if (started) begin
    check("cpu_hold", {7'd0, cpu_hold}, {7'd0, m_hold});
    check("ld_ack", {7'd0, ld_ack}, {7'd0, m_ack});
    check("bus_err", {7'd0, bus_err}, {7'd0, m_err});
    check("out_port", out_port, m_out);
    if (m_rk) check("cpu_rdata", cpu_rdata, m_rdata);
    if (m_dk) check("resdt", resdt, m_resdt);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  initial begin
    reset = 1; adrs = 0; cpu_wdata = 0; mmrd_N = 1; mmwr_N = 1; ld_req = 0;
    ld_adrs = 0; ld_data = 0; in_port = 0; resad = 0; m_writes = 0;
    tick(2);
    check("rst_rdata", cpu_rdata, 8'h00);
    check("rst_hold", {7'd0, cpu_hold}, 8'h00);
    check("rst_err", {7'd0, bus_err}, 8'h00);
    reset = 0;
    // T1: long write strobe gives one write, then read back
    adrs = 8'h10; cpu_wdata = 8'hA5; mmwr_N = 0; tick(3);
    mmwr_N = 1; tick();
    mmrd_N = 0; tick();
    check("t1_rdata", cpu_rdata, 8'hA5);
    check("t1_writes", m_writes[7:0], 8'd1);
    mmrd_N = 1; resad = 8'h10; tick();
    check("t1_resdt", resdt, 8'hA5);
    // read-after-write in consecutive cycles
    adrs = 8'h50; cpu_wdata = 8'hC3; mmwr_N = 0; tick();
    mmwr_N = 1; mmrd_N = 0; tick();
    check("raw_rdata", cpu_rdata, 8'hC3);
    mmrd_N = 1; tick();
    // T2: I/O byte
    adrs = 8'hFF; cpu_wdata = 8'h3C; mmwr_N = 0; tick();
    mmwr_N = 1; tick();
    check("t2_out", out_port, 8'h3C);
    in_port = 8'h81; mmrd_N = 0; resad = 8'hFF; tick();
    check("t2_rdata", cpu_rdata, 8'h81);
    check("t2_resdt", resdt, 8'h3C);
    mmrd_N = 1; tick();
    // T3: loader with idle CPU
    ld_req = 1; ld_adrs = 8'h20; ld_data = 8'h5A; tick();
    check("t3_hold", {7'd0, cpu_hold}, 8'h01);
    check("t3_ack0", {7'd0, ld_ack}, 8'h00);
    tick();
    check("t3_ack1", {7'd0, ld_ack}, 8'h00);
    tick();
    check("t3_ack2", {7'd0, ld_ack}, 8'h01);
    ld_req = 0; tick();
    check("t3_ackoff", {7'd0, ld_ack}, 8'h00);
    check("t3_holdoff", {7'd0, cpu_hold}, 8'h00);
    resad = 8'h20; tick();
    check("t3_resdt", resdt, 8'h5A);
    // T4: loader waits while CPU reads
    adrs = 8'h10; mmrd_N = 0; ld_req = 1; ld_adrs = 8'h21; ld_data = 8'h6B; tick();
    check("t4_hold", {7'd0, cpu_hold}, 8'h01);
    tick(3);
    check("t4_wait", {7'd0, ld_ack}, 8'h00);
    check("t4_rdata", cpu_rdata, 8'hA5);
    mmrd_N = 1; tick();
    check("t4_ack0", {7'd0, ld_ack}, 8'h00);
    tick();
    check("t4_ack1", {7'd0, ld_ack}, 8'h01);
    ld_req = 0; tick();
    resad = 8'h21; tick();
    check("t4_resdt", resdt, 8'h6B);
    // T5: simultaneous strobes
    adrs = 8'h30; cpu_wdata = 8'h11; mmwr_N = 0; tick();
    mmwr_N = 1; tick();
    cpu_wdata = 8'h77; mmrd_N = 0; mmwr_N = 0; tick();
    check("t5_err", {7'd0, bus_err}, 8'h01);
    check("t5_rdata", cpu_rdata, 8'h11);
    mmrd_N = 1; mmwr_N = 1; tick(10);
    check("t5_sticky", {7'd0, bus_err}, 8'h01);
    resad = 8'h30; tick();
    check("t5_mem", resdt, 8'h11);
    // T6: reset while loader is in HOLD
    adrs = 8'h40; cpu_wdata = 8'h22; mmwr_N = 0; tick();
    mmwr_N = 1; tick();
    mmrd_N = 0; ld_req = 1; ld_adrs = 8'h40; ld_data = 8'hEE; tick(2);
    check("t6_hold", {7'd0, cpu_hold}, 8'h01);
    reset = 1; tick();
    check("t6_hold0", {7'd0, cpu_hold}, 8'h00);
    check("t6_ack0", {7'd0, ld_ack}, 8'h00);
    check("t6_out0", out_port, 8'h00);
    check("t6_err0", {7'd0, bus_err}, 8'h00);
    reset = 0; ld_req = 0; mmrd_N = 1; tick();
    mmrd_N = 0; tick();
    check("t6_mem", cpu_rdata, 8'h22);
    mmrd_N = 1; tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
